// File: rtl/dmem_bytewise.sv
// Byte-addressable data memory: byte/half/word stores, sign/zero-extended loads with
// 1-cycle read latency, fault detection and a post-reset zeroing sweep. Define DMEM_DISPLAY_EN to trace stores.
module dmem_bytewise #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state_reg;
  logic [DEPTH_LOG2-1:0] clear_ptr_reg;
  logic                  busy_reg;
  logic                  addr_err_reg;
  logic [1:0]            ld_size_reg;
  logic [1:0]            ld_lane_reg;
  logic                  ld_unsigned_reg;

  logic [31:0]           off;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fault;
  logic                  accept;
  logic                  store_go;
  logic                  load_go;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [3:0]            lane_we;
  logic [31:0]           lane_wdata;
  logic [3:0][7:0]       lane_q;
  logic [31:0]           old_word;

  // Request decode: offsets below BASE_ADDR wrap high and fall out of range.
  assign off          = addr - BASE_ADDR;
  assign out_of_range = (off >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign req_idx      = off[DEPTH_LOG2+1:2];

  always_comb begin
    misaligned = 1'b0;
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = addr[1:0] != 2'b00;
      default: misaligned = 1'b1;
    endcase
  end

  assign fault    = misaligned || out_of_range;
  assign accept   = !reset && (state_reg == ST_READY) && req_valid && !fault;
  assign store_go = accept && we;
  assign load_go  = accept && !we;

  // Write port is shared between the zeroing sweep and store requests.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = wdata;
    wr_idx     = req_idx;
    if (state_reg == ST_CLEAR) begin
      lane_we    = 4'b1111;
      lane_wdata = 32'h0;
      wr_idx     = clear_ptr_reg;
    end else if (store_go) begin
      case (size)
        2'b00: begin
          lane_we    = 4'b0001 << addr[1:0];
          lane_wdata = {4{wdata[7:0]}};
        end
        2'b01: begin
          lane_we    = addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{wdata[15:0]}};
        end
        default: begin
          lane_we    = 4'b1111;
          lane_wdata = wdata;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (lane_we[gi]) begin
          lane_mem[wr_idx] <= lane_wdata[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          lane_q_reg <= 8'h00;
        end else if (load_go) begin
          lane_q_reg <= lane_mem[req_idx];
        end
      end

      assign lane_q[gi]           = lane_q_reg;
      assign old_word[gi*8 +: 8] = lane_mem[req_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_CLEAR;
      clear_ptr_reg   <= '0;
      busy_reg        <= 1'b1;
      addr_err_reg    <= 1'b0;
      ld_size_reg     <= 2'b10;
      ld_lane_reg     <= 2'b00;
      ld_unsigned_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          addr_err_reg  <= 1'b0;
          clear_ptr_reg <= clear_ptr_reg + 1'b1;
          if (&clear_ptr_reg) begin
            state_reg <= ST_READY;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          addr_err_reg <= req_valid && fault;
          if (load_go) begin
            ld_size_reg     <= size;
            ld_lane_reg     <= addr[1:0];
            ld_unsigned_reg <= load_unsigned;
          end
        end
      endcase
    end
  end

  // Lane select and extension act on the captured RAM output, so rdata holds between loads.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = lane_q[ld_lane_reg];
    sel_half = ld_lane_reg[1] ? {lane_q[3], lane_q[2]} : {lane_q[1], lane_q[0]};
    case (ld_size_reg)
      2'b00:   rdata = {{24{!ld_unsigned_reg && sel_byte[7]}}, sel_byte};
      2'b01:   rdata = {{16{!ld_unsigned_reg && sel_half[15]}}, sel_half};
      default: rdata = lane_q;
    endcase
  end

  assign busy     = busy_reg;
  assign addr_err = addr_err_reg;

`ifdef DMEM_DISPLAY_EN
  logic [31:0] merged_word;

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) merged_word[i*8 +: 8] = lane_wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (store_go) begin
      $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged_word);
    end
  end
`else
  logic unused_sigs;
  assign unused_sigs = ^{pc, old_word};
`endif

endmodule

// File: tb/tb_dmem_bytewise.sv
// Randomized bench for dmem_bytewise (16-word build): a byte-array model predicts
// rdata and addr_err for every transaction; directed cases cover sweep timing and faults.
module tb_dmem_bytewise;

  localparam int          DL   = 4;
  localparam int          NB   = 4 * (1 << DL);
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic        busy;
  logic        addr_err;

  always #5 clk = ~clk;

  dmem_bytewise #(.DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .we(we), .addr(addr),
    .wdata(wdata), .size(size), .load_unsigned(load_unsigned), .pc(pc),
    .rdata(rdata), .busy(busy), .addr_err(addr_err)
  );

  int          total = 0;
  int          bad   = 0;
  int          n_xact = 0;
  logic [7:0]  ref_mem [NB];
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
    logic [31:0] o;
    o = a - BASE;
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
    if (o >= 32'(NB)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic xact(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit u);
    bit          flt;
    int          o;
    int          nbytes;
    logic [31:0] val;
    req_valid = v; we = w; addr = a; wdata = d; size = sz; load_unsigned = u;
    pc = $urandom;
    flt = v && model_fault(a, sz);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (v && !flt) begin
      o = int'(a - BASE);
      if (w) begin
        for (int k = 0; k < nbytes; k++) ref_mem[o + k] = 8'((d >> (8 * k)) & 32'hFF);
      end else begin
        val = 32'd0;
        for (int k = 0; k < nbytes; k++) val = val + (32'(ref_mem[o + k]) << (8 * k));
        if (!u && nbytes < 4 && val >= (32'd1 << (8 * nbytes - 1)))
          val = val - (32'd1 << (8 * nbytes));
        exp_rdata = val;
      end
    end
    @(posedge clk);
    #1;
    n_xact++;
    $display("xact %0d v=%0b we=%0b addr=%h size=%0d uns=%0b wdata=%h -> rdata=%h err=%0b",
             n_xact, v, w, a, sz, u, d, rdata, addr_err);
    check("rdata", rdata, exp_rdata);
    check("addr_err", addr_err, 32'(flt));
    check("busy_ready", busy, 32'd0);
    req_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int r;
    logic [31:0] ra;
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    exp_rdata = 32'h0;
    reset = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    size = 2'd0; load_unsigned = 1'b0; pc = '0;

    @(posedge clk);
    #1;
    check("rst_busy", busy, 32'd1);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", addr_err, 32'd0);
    reset = 1'b0;

    // Store held on the bus throughout the sweep; it must be ignored.
    req_valid = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'hDEAD_BEEF; size = 2'd2;
    repeat (7) @(posedge clk);
    #1;
    check("mid_busy", busy, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      check("sweep_err", addr_err, 32'd0);
      check("sweep_rdata", rdata, 32'h0);
    end
    check("busy_cycles", cnt, 32'd16);
    req_valid = 1'b0;

    for (int i = 0; i < NB / 4; i++) xact(1, 0, BASE + 32'(4 * i), 0, 2'd2, 0);

    xact(1, 1, 32'h8, 32'h1122_3344, 2'd2, 0);
    xact(1, 0, 32'h9, 0, 2'd0, 0);  check("lb_9", rdata, 32'h0000_0033);
    xact(1, 0, 32'hA, 0, 2'd1, 1);  check("lhu_a", rdata, 32'h0000_1122);
    xact(1, 0, 32'h8, 0, 2'd2, 0);  check("lw_8", rdata, 32'h1122_3344);

    xact(1, 1, 32'h0, 32'h0000_00FF, 2'd2, 0);
    xact(1, 1, 32'h1, 32'h0000_0080, 2'd0, 0);
    xact(1, 0, 32'h1, 0, 2'd0, 0);  check("lb_1", rdata, 32'hFFFF_FF80);
    xact(1, 0, 32'h1, 0, 2'd0, 1);  check("lbu_1", rdata, 32'h0000_0080);
    xact(1, 0, 32'h0, 0, 2'd2, 0);  check("lw_0", rdata, 32'h0000_80FF);

    xact(1, 1, 32'h3, 32'hAAAA_5555, 2'd1, 0);
    xact(0, 0, 32'h0, 0, 2'd0, 0);
    xact(1, 0, 32'h2, 0, 2'd2, 0);
    xact(1, 1, 32'h0, 32'h1234_5678, 2'd3, 0);
    xact(1, 0, 32'h40, 0, 2'd2, 0);
    xact(1, 1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 2'd2, 0);
    check("fault_hold", rdata, 32'h0000_80FF);
    xact(1, 0, 32'h0, 0, 2'd2, 0);  check("lw_0_after", rdata, 32'h0000_80FF);

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = 32'($urandom_range(NB - 4, NB + 4));
      else             ra = 32'($urandom_range(0, NB - 1));
      xact($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, ra, $urandom,
           ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < NB / 4; i++) xact(1, 0, BASE + 32'(4 * i), 0, 2'd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bytewise.md
Name: dmem_bytewise

Overview:
Parametrised data memory, successor to the word-only DMEM. Adds byte/halfword/word stores, sign- or zero-extended loads and a registered read with 1-cycle latency. Also adds alignment/range checking and a post-reset clearing sweep. Sits in the MEM stage between ALU address output and the writeback mux.

Parameters:
DEPTH_LOG2, 12, log2 of memory depth in 32-bit words (depth = 2^DEPTH_LOG2)
BASE_ADDR, 32'h0000_0000, byte address mapped to word 0

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  access request this cycle
we  input  1  1 = store, 0 = load (qualified by req_valid)
addr  input  32  byte address
wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
size  input  2  00 byte, 01 half, 10 word, 11 illegal
load_unsigned  input  1  1 = zero-extend byte/half loads, 0 = sign-extend
pc  input  32  PC of requesting instruction (used only by the optional feature)
rdata  output  32  load result, registered
busy  output  1  memory clearing, requests ignored
addr_err  output  1  one-cycle pulse: previous request faulted

Behaviour:
- Clock is clk; reset is synchronous and active-high. No negedge logic.
- FSM states: CLEAR, READY.
- Reset: state=CLEAR, clear_ptr=0, busy=1, rdata=0, addr_err=0.
- CLEAR:
  - Each cycle writes 32'h0 to mem[clear_ptr] and increments clear_ptr.
  - When clear_ptr==2^DEPTH_LOG2-1, the zero write occurs; the next state is READY with busy=0.
  - Total busy time after reset deasserts: 2^DEPTH_LOG2 cycles.
  - Reset asserted mid-sweep restarts the sweep at 0.
  - req_valid is ignored while busy: no write, no rdata change, no addr_err.
- READY: one request per cycle, accepted when req_valid=1.
  - off = addr - BASE_ADDR (32-bit wrap).
  - Fault if any of: size==11; size==01 and addr[0]; size==10 and addr[1:0]!=0; off >= 4*2^DEPTH_LOG2.
  - On fault: no write, rdata holds its value, addr_err=1 on the next cycle only.
  - Word index = off[DEPTH_LOG2+1:2].
  - Store (we=1), committed at posedge:
    - byte writes wdata[7:0] into lane addr[1:0];
    - half writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
    - word writes all 4 lanes.
    - Other lanes are unchanged. rdata is unchanged.
  - Load (we=0):
    - rdata updates at the posedge after the request (latency 1) with the selected lane(s).
    - Byte/half results are extended per load_unsigned; word results are unchanged.
  - Lane 0 = bits [7:0] (little-endian).
  - rdata holds its value when there is no valid load.
- Store followed by a load to the same word next cycle returns the new data. No bypass is needed, since the write is committed first.
- Address wrap: a BASE_ADDR-relative offset that underflows wraps to a large value and faults as out of range.

Optional Feature:
DMEM_DISPLAY_EN: when defined, each committed store issues $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2],2'b00}, merged_word). merged_word is the full 32-bit word after the lane merge. Faulted or ignored requests print nothing. When undefined, no display is issued and pc is unused.

Test Plan:
- Reset 1 cycle, DEPTH_LOG2=4 -> busy=1 for exactly 16 cycles then 0. A load of any word after busy=0 returns 0. A store issued during busy is ignored; a later read still returns 0.
- sw 0x11223344 @0x8; lb @0x9 signed -> 0x00000033; lh @0xA unsigned -> 0x00001122; lw @0x8 -> 0x11223344. Each result appears 1 cycle after its request.
- sw 0x000000FF @0x0; sb 0x80 @0x1; lb @0x1 signed -> 0xFFFFFF80; lbu @0x1 -> 0x00000080; lw @0x0 -> 0x000080FF.
- sh @0x3, lw @0x2, size=11 @0x0, lw @0x40 with depth 16 -> addr_err pulses 1 cycle after each. Memory and rdata are unchanged.
- Assert reset mid-sweep at clear_ptr=7 -> sweep restarts at 0. busy stays high for 16 cycles after the reset is released.
- With DMEM_DISPLAY_EN, sb 0xAB @0x5, pc=0x3000 -> one line showing 00003000, 00000004, and the merged word with byte 1 = AB.
